// File: rtl/axis_mux_pkg.sv
// Shared types, arbitration constants and the round-robin search helper
// for the packet-aware AXI-Stream mux.
package axis_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  localparam int unsigned ARB_SELECT = 0;
  localparam int unsigned ARB_RR     = 1;
  localparam int unsigned MAX_INPUTS = 16;

  // Returns {found, index}: first valid channel after ptr, wrapping modulo n.
  function automatic logic [4:0] next_rr_grant(input logic [MAX_INPUTS-1:0] valid,
                                               input logic [3:0]            ptr,
                                               input int unsigned           n);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_INPUTS; k++) begin
      idx = 4'((32'(ptr) + k) % n);
      if (k <= n && !res[4] && valid[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: upstream ready is a flop, full throughput,
// payload held stable while the sink stalls.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic             push;

  // Full only when the skid slot holds a beat.
  assign in_ready_o = !skid_valid_q;
  assign push       = in_valid_i && !skid_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= push;
        if (push) begin
          out_data_q <= in_data_i;
        end
      end
    end else if (push) begin
      skid_data_q  <= in_data_i;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_pkt_mux_n.sv
// Packet-aware N:1 AXI-Stream mux; the channel is chosen per packet from a
// select stream or by round-robin, and switches only after tlast.
module axis_pkt_mux_n
  import axis_mux_pkg::*;
#(
  parameter int unsigned  NUM_INPUTS = 4,
  parameter int unsigned  DATA_WIDTH = 8,
  parameter int unsigned  ARB_MODE   = ARB_SELECT,
  localparam int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [SEL_WIDTH-1:0]             sel_tdata,
  input  logic                             sel_tvalid,
  output logic                             sel_tready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_tdata,
  input  logic [NUM_INPUTS-1:0]            input_tvalid,
  input  logic [NUM_INPUTS-1:0]            input_tlast,
  output logic [NUM_INPUTS-1:0]            input_tready,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic                             output_valid,
  output logic                             output_last,
  input  logic                             output_ready,
  output logic [SEL_WIDTH-1:0]             active_ch,
  output logic                             busy,
  output logic                             sel_err
);

  state_t                state_q;
  logic [SEL_WIDTH-1:0]  active_q;
  logic [SEL_WIDTH-1:0]  rr_q;
  logic                  sel_ready_q;
  logic                  sel_err_q;
  logic                  buf_ready;
  logic                  beat_valid;
  logic                  beat_last;
  logic                  beat_xfer;
  logic                  sel_fire;
  logic                  sel_in_range;
  logic [4:0]            rr_res;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [DATA_WIDTH:0]   out_payload;

  assign beat_data    = input_tdata[active_q*DATA_WIDTH +: DATA_WIDTH];
  assign beat_last    = input_tlast[active_q];
  assign beat_valid   = (state_q == PASS) && input_tvalid[active_q];
  assign beat_xfer    = beat_valid && buf_ready;
  assign sel_fire     = sel_tvalid && sel_ready_q;
  assign sel_in_range = 32'(sel_tdata) < NUM_INPUTS;
  assign rr_res       = next_rr_grant(MAX_INPUTS'(input_tvalid), 4'(rr_q), NUM_INPUTS);

  // Only the granted channel ever sees ready.
  always_comb begin
    input_tready = '0;
    if (state_q == PASS) begin
      input_tready[active_q] = buf_ready;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      active_q    <= '0;
      rr_q        <= SEL_WIDTH'(NUM_INPUTS - 1);
      sel_ready_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ARB_MODE == ARB_RR) begin
            if (rr_res[4]) begin
              active_q <= SEL_WIDTH'(rr_res[3:0]);
              state_q  <= PASS;
            end
          end else begin
            sel_ready_q <= 1'b1;
            if (sel_fire) begin
              if (sel_in_range) begin
                active_q    <= sel_tdata;
                state_q     <= PASS;
                sel_ready_q <= 1'b0;
              end else begin
                sel_err_q <= 1'b1;
              end
            end
          end
        end
        PASS: begin
          if (beat_xfer && beat_last) begin
            state_q     <= IDLE;
            rr_q        <= active_q;
            sel_ready_q <= (ARB_MODE == ARB_SELECT);
          end
        end
      endcase
    end
  end

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data_i  ({beat_last, beat_data}),
    .in_valid_i (beat_valid),
    .in_ready_o (buf_ready),
    .out_data_o (out_payload),
    .out_valid_o(output_valid),
    .out_ready_i(output_ready)
  );

  assign output_data = out_payload[DATA_WIDTH-1:0];
  assign output_last = out_payload[DATA_WIDTH];
  assign sel_tready  = sel_ready_q;
  assign active_ch   = active_q;
  assign busy        = (state_q == PASS);
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_axis_pkt_mux_n.sv
// Directed bench for axis_pkt_mux_n: packet-order scoreboard on the main
// instance, plus small instances for out-of-range select and round-robin.
module tb_axis_pkt_mux_n;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  typedef logic [7:0] pkt_t[4];

  logic clk = 1'b0;
  logic reset_n;

  // Main instance: 4 inputs, explicit select.
  logic [SW-1:0]   sel_tdata;
  logic            sel_tvalid, sel_tready;
  logic [N*DW-1:0] input_tdata;
  logic [N-1:0]    input_tvalid, input_tlast, input_tready;
  logic [DW-1:0]   output_data;
  logic            output_valid, output_last, output_ready;
  logic [SW-1:0]   active_ch;
  logic            busy, sel_err;

  // Instance B: 3 inputs, explicit select.
  logic [1:0]  b_sel_tdata;
  logic        b_sel_tvalid, b_sel_tready;
  logic [23:0] b_input_tdata;
  logic [2:0]  b_input_tvalid, b_input_tlast, b_input_tready;
  logic [7:0]  b_output_data;
  logic        b_output_valid, b_output_last, b_output_ready;
  logic [1:0]  b_active_ch;
  logic        b_busy, b_sel_err;

  // Instance C: 4 inputs, round-robin.
  logic [SW-1:0]   c_sel_tdata;
  logic            c_sel_tvalid, c_sel_tready;
  logic [N*DW-1:0] c_input_tdata;
  logic [N-1:0]    c_input_tvalid, c_input_tlast, c_input_tready;
  logic [DW-1:0]   c_output_data;
  logic            c_output_valid, c_output_last, c_output_ready;
  logic [SW-1:0]   c_active_ch;
  logic            c_busy, c_sel_err;

  axis_pkt_mux_n #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ARB_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .sel_tdata(sel_tdata), .sel_tvalid(sel_tvalid), .sel_tready(sel_tready),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tlast(input_tlast),
    .input_tready(input_tready),
    .output_data(output_data), .output_valid(output_valid), .output_last(output_last),
    .output_ready(output_ready),
    .active_ch(active_ch), .busy(busy), .sel_err(sel_err)
  );

  axis_pkt_mux_n #(.NUM_INPUTS(3), .DATA_WIDTH(DW), .ARB_MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .sel_tdata(b_sel_tdata), .sel_tvalid(b_sel_tvalid), .sel_tready(b_sel_tready),
    .input_tdata(b_input_tdata), .input_tvalid(b_input_tvalid), .input_tlast(b_input_tlast),
    .input_tready(b_input_tready),
    .output_data(b_output_data), .output_valid(b_output_valid), .output_last(b_output_last),
    .output_ready(b_output_ready),
    .active_ch(b_active_ch), .busy(b_busy), .sel_err(b_sel_err)
  );

  axis_pkt_mux_n #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_c (
    .clk(clk), .reset_n(reset_n),
    .sel_tdata(c_sel_tdata), .sel_tvalid(c_sel_tvalid), .sel_tready(c_sel_tready),
    .input_tdata(c_input_tdata), .input_tvalid(c_input_tvalid), .input_tlast(c_input_tlast),
    .input_tready(c_input_tready),
    .output_data(c_output_data), .output_valid(c_output_valid), .output_last(c_output_last),
    .output_ready(c_output_ready),
    .active_ch(c_active_ch), .busy(c_busy), .sel_err(c_sel_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: beats expected at the output, in select order, and the only
  // channel allowed to see ready.
  logic [8:0]   exp_q[$];
  logic [N-1:0] allowed = '0;
  int           in_cyc_q[$];
  int           out_cyc_q[$];
  logic [8:0]   out_dat_q[$];
  logic         was_stall = 1'b0;
  logic [8:0]   held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  // Per-cycle compare for the main instance.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (!reset_n) begin
      was_stall = 1'b0;
    end else begin
      if (was_stall) begin
        check("hold_valid", output_valid, 1);
        check("hold_beat", {output_last, output_data}, held);
      end
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_beat: got %0h, expected no beat", {output_last, output_data});
        end else begin
          e = exp_q.pop_front();
          check("out_beat", {output_last, output_data}, e);
        end
        out_cyc_q.push_back(cyc);
        out_dat_q.push_back({output_last, output_data});
      end
      check("tready_grant", input_tready & ~allowed, 0);
      was_stall = output_valid && !output_ready;
      held = {output_last, output_data};
    end
  end

  task automatic send_sel(input int ch, input pkt_t pkt, input int n, output int acc_cyc);
    int tmo = 0;
    acc_cyc = -1;
    @(negedge clk);
    sel_tdata  = SW'(ch);
    sel_tvalid = 1'b1;
    while (!sel_tready && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 200) begin
      fail_timeout("sel_timeout");
    end else begin
      acc_cyc = cyc;
      @(posedge clk);
      allowed     = '0;
      allowed[ch] = 1'b1;
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pkt[i]});
    end
    @(negedge clk);
    sel_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input pkt_t pkt, input int n, output int last_cyc);
    int tmo;
    last_cyc = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      input_tdata[ch*DW +: DW] = pkt[i];
      input_tvalid[ch] = 1'b1;
      input_tlast[ch]  = (i == n - 1);
      tmo = 0;
      while (!input_tready[ch] && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 200) begin
        fail_timeout("pkt_timeout");
        break;
      end
      in_cyc_q.push_back(cyc);
      last_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    input_tvalid[ch] = 1'b0;
    input_tlast[ch]  = 1'b0;
  endtask

  initial begin
    int a0, a1, l0, l1, got;
    pkt_t p;
    pkt_t q;
    logic [8:0] c_got[$];
    logic [8:0] exp5[6];
    logic [8:0] exp3[4];
    logic [7:0] pat;

    reset_n = 1'b1;
    sel_tdata = '0; sel_tvalid = 1'b0;
    input_tdata = '0; input_tvalid = '0; input_tlast = '0; output_ready = 1'b1;
    b_sel_tdata = '0; b_sel_tvalid = 1'b0;
    b_input_tdata = '0; b_input_tvalid = '0; b_input_tlast = '0; b_output_ready = 1'b1;
    c_sel_tdata = '0; c_sel_tvalid = 1'b0;
    c_input_tdata = '0; c_input_tvalid = '0; c_input_tlast = '0; c_output_ready = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", output_valid, 0);
    check("rst_data", output_data, 0);
    check("rst_last", output_last, 0);
    check("rst_tready", input_tready, 0);
    check("rst_sel_tready", sel_tready, 0);
    check("rst_active", active_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_sel_err", sel_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #2 check("post_rst_sel_tready", sel_tready, 1);

    // T1: ch2 three-beat packet, one-cycle latency, back-to-back output.
    in_cyc_q.delete(); out_cyc_q.delete(); out_dat_q.delete();
    p = '{8'h11, 8'h22, 8'h33, 8'h00};
    send_sel(2, p, 3, a0);
    send_pkt(2, p, 3, l0);
    repeat (4) @(negedge clk);
    check("t1_count", out_dat_q.size(), 3);
    if (out_dat_q.size() == 3 && in_cyc_q.size() == 3) begin
      check("t1_beat0", out_dat_q[0], 9'h011);
      check("t1_beat1", out_dat_q[1], 9'h022);
      check("t1_beat2", out_dat_q[2], 9'h133);
      for (int i = 0; i < 3; i++) check("t1_latency", out_cyc_q[i] - in_cyc_q[i], 1);
      check("t1_consecutive", out_cyc_q[2] - out_cyc_q[0], 2);
    end

    // T2: second select issued mid-packet; ch1 and ch3 already valid.
    p = '{8'h40, 8'h41, 8'h42, 8'h43};
    q = '{8'h55, 8'h66, 8'h00, 8'h00};
    send_sel(0, p, 4, a0);
    input_tdata[3*DW +: DW] = 8'hEE;
    input_tvalid[3] = 1'b1;
    input_tlast[3]  = 1'b1;
    fork
      send_pkt(0, p, 4, l0);
      begin
        repeat (2) @(negedge clk);
        #2;
        check("t2_sel_blocked", sel_tready, 0);
        check("t2_busy", busy, 1);
        check("t2_active", active_ch, 0);
        send_sel(1, q, 2, a1);
      end
      send_pkt(1, q, 2, l1);
    join
    check("t2_sel_after_last", 32'(a1 > l0), 1);
    input_tvalid[3] = 1'b0;
    input_tlast[3]  = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_drained", exp_q.size(), 0);

    // T3: output backpressure during a four-beat ch1 packet.
    out_dat_q.delete();
    p = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    pat = 8'b1110_1001;
    send_sel(1, p, 4, a0);
    fork
      send_pkt(1, p, 4, l0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        output_ready = pat[i];
      end
    join
    @(negedge clk);
    output_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_drained", exp_q.size(), 0);
    check("t3_count", out_dat_q.size(), 4);
    exp3 = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
    if (out_dat_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t3_beat", out_dat_q[i], exp3[i]);
    end

    // T4: out-of-range select on the 3-input instance.
    b_input_tvalid = 3'b111;
    b_input_tlast  = 3'b111;
    b_input_tdata  = 24'h030201;
    @(negedge clk);
    b_sel_tdata  = 2'd3;
    b_sel_tvalid = 1'b1;
    #1 check("t4_sel_ready", b_sel_tready, 1);
    @(posedge clk);
    @(negedge clk);
    b_sel_tvalid = 1'b0;
    #2;
    check("t4_err_pulse", b_sel_err, 1);
    check("t4_idle", b_busy, 0);
    check("t4_no_tready", b_input_tready, 0);
    check("t4_sel_ready_after", b_sel_tready, 1);
    @(negedge clk);
    #2 check("t4_err_one_cycle", b_sel_err, 0);
    check("t4_still_no_tready", b_input_tready, 0);
    @(negedge clk);
    b_sel_tdata  = 2'd2;
    b_sel_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_sel_tvalid = 1'b0;
    #2;
    check("t4_busy_valid_sel", b_busy, 1);
    check("t4_active", b_active_ch, 2);
    check("t4_tready_ch2", b_input_tready, 3'b100);
    check("t4_no_err", b_sel_err, 0);
    b_input_tvalid = '0;

    // T5: round-robin over channels 0,1,3 with one-beat packets.
    c_input_tdata  = {8'h13, 8'h00, 8'h11, 8'h10};
    c_input_tlast  = '1;
    c_sel_tdata    = 2'd2;
    c_sel_tvalid   = 1'b1;
    @(negedge clk);
    c_input_tvalid = 4'b1011;
    for (int k = 0; k < 60 && c_got.size() < 6; k++) begin
      @(negedge clk);
      #2;
      if (c_output_valid && c_output_ready) c_got.push_back({c_output_last, c_output_data});
      check("t5_ch2_never", c_input_tready[2], 0);
      check("t5_sel_tready", c_sel_tready, 0);
    end
    c_input_tvalid = '0;
    c_sel_tvalid   = 1'b0;
    check("t5_count", c_got.size(), 6);
    exp5 = '{9'h110, 9'h111, 9'h113, 9'h110, 9'h111, 9'h113};
    if (c_got.size() == 6) begin
      for (int i = 0; i < 6; i++) check("t5_order", c_got[i], exp5[i]);
    end

    // T6: reset after two of four beats while the sink is stalled.
    output_ready = 1'b0;
    p = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    send_sel(0, p, 4, a0);
    got = 0;
    @(negedge clk);
    input_tdata[DW-1:0] = 8'hC0;
    input_tvalid[0] = 1'b1;
    input_tlast[0]  = 1'b0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      if (input_tready[0]) got++;
      @(posedge clk);
      @(negedge clk);
      input_tdata[DW-1:0] = 8'hC0 + 8'(got);
    end
    check("t6_two_beats", got, 2);
    check("t6_pre_valid", output_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_valid_drop", output_valid, 0);
    check("t6_last_drop", output_last, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_tready_drop", input_tready, 0);
    exp_q.delete();
    allowed = '0;
    input_tvalid = '0;
    input_tlast  = '0;
    out_dat_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    output_ready = 1'b1;
    @(negedge clk);
    #2 check("t6_sel_tready", sel_tready, 1);
    repeat (8) @(negedge clk);
    check("t6_no_stale", out_dat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_pkt_mux_n.md
Name: axis_pkt_mux_n

Overview:
- Parametrised N-input, packet-aware AXI-Stream multiplexer; successor to the fixed 2-input axi_mux.
- Sits between several packet sources and one sink. Channel is chosen per packet, either from a select stream or by round-robin arbitration.
- Switches only on packet boundaries (tlast). Output is fully registered through a skid buffer, giving full throughput with registered ready/valid.

Parameters:
- NUM_INPUTS, 4, number of input streams (2..16).
- DATA_WIDTH, 8, tdata width in bits.
- ARB_MODE, 0, 0 = explicit select via sel stream; 1 = round-robin, sel stream ignored.
- SEL_WIDTH, $clog2(NUM_INPUTS), localparam, select/channel index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel_tdata  in  SEL_WIDTH  requested input channel for the next packet.
- sel_tvalid  in  1  select valid.
- sel_tready  out  1  select accepted (IDLE, ARB_MODE=0 only).
- input_tdata  in  NUM_INPUTS*DATA_WIDTH  flattened; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- input_tvalid  in  NUM_INPUTS  per-channel valid.
- input_tlast  in  NUM_INPUTS  per-channel end of packet.
- input_tready  out  NUM_INPUTS  per-channel ready; at most one bit set.
- output_data  out  DATA_WIDTH  muxed data (registered).
- output_valid  out  1  output valid (registered).
- output_last  out  1  output end of packet (registered).
- output_ready  in  1  sink ready.
- active_ch  out  SEL_WIDTH  channel currently granted; held after packet end.
- busy  out  1  high in PASS state.
- sel_err  out  1  one-cycle pulse when an out-of-range select is consumed.

Behaviour:
- Reset (async assert, sync release): output_valid=0, output_data=0, output_last=0, input_tready=0, sel_tready=0, active_ch=0, busy=0, sel_err=0, skid buffer empty, state=IDLE, rr pointer=NUM_INPUTS-1.
- FSM states IDLE and PASS (enum in package).
- IDLE, ARB_MODE=0:
  - sel_tready=1.
  - On sel_tvalid&&sel_tready with sel_tdata<NUM_INPUTS: latch active_ch; PASS next cycle.
  - On sel_tdata>=NUM_INPUTS: consume the select, pulse sel_err next cycle, stay IDLE.
- IDLE, ARB_MODE=1:
  - sel_tready=0.
  - Grant the first channel with tvalid=1, searching from rr pointer+1 upward with wrap-around; enter PASS next cycle.
  - No valid channel: stay IDLE.
- PASS:
  - input_tready[active_ch] = skid buffer not full; all other bits 0.
  - sel_tready=0, so select changes mid-packet are impossible.
  - A beat transfers when input_tvalid[active_ch]&&input_tready[active_ch].
  - A transferred beat with tlast=1 returns the FSM to IDLE next cycle and updates rr pointer=active_ch.
  - Next packet's select may be accepted in that IDLE cycle, giving a 1-cycle bubble between packets.
- Output stage: 2-entry skid buffer.
  - Latency 1 cycle from input transfer to output_valid.
  - Sustains 1 beat/cycle while output_ready=1.
  - Holds data/last stable while output_valid&&!output_ready.
  - Upstream ready is registered (buffer not-full), never combinationally from output_ready.
- output_data/output_last change only when output_valid&&output_ready, or when loading an empty buffer.
- Simultaneous tlast transfer and output stall: the beat is stored; FSM still returns to IDLE; the following packet's beats wait on buffer space.
- Zero-length packets are not possible: every packet carries ≥1 beat.
- Reset mid-packet aborts immediately: buffered beats are discarded, no tlast is generated, and the FSM restarts in IDLE.
- Inputs not granted are never acknowledged, whatever their tvalid.

Decomposition:
- Package axis_mux_pkg: state_t enum {IDLE, PASS}; ARB_SELECT=0, ARB_RR=1 constants; function next_rr_grant(valid vector, pointer).
- Sub-module axis_skid_buf (DATA_WIDTH+1 wide payload, same clk/reset_n), instantiated once for the output stage.
- Top module holds the FSM, grant/mux logic, and the rr pointer.

Test Plan:
- ARB_MODE=0, NUM_INPUTS=4: sel=2; ch2 sends 3 beats 0x11,0x22,0x33(last); output_ready=1 → output shows 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after first acceptance; output_last only on 0x33; input_tready[0,1,3]=0 throughout.
- Mid-packet select: sel=0 accepted; send sel=1 during the ch0 packet → sel_tready=0 until ch0 tlast transfers; the ch1 packet (0x55,0x66 last) follows ch0's packet with no interleaving.
- Backpressure: output_ready toggles 1,0,0,1 during a 4-beat ch1 packet 0xA0..0xA3 → all four beats appear in order, none lost or duplicated; data stable while stalled.
- Out-of-range: NUM_INPUTS=3, sel_tdata=3 → sel_err pulses one cycle; no input_tready asserted; state stays IDLE.
- ARB_MODE=1: channels 0,1,3 all valid with 1-beat packets (0x10,0x11,0x13) → grant order 0,1,3,0…; channel 2 never granted.
- Reset mid-packet: reset_n low after 2 of 4 beats of 0xC0..0xC3 → output_valid=0 immediately; after release, sel_tready=1 (mode 0) and no stale beats appear.
